// File: rtl/fxp_pkg.sv
// Shared definitions for the Q8.8 fixed-point arithmetic blocks.
package fxp_pkg;

  localparam int FXP_W    = 16;
  localparam int FXP_FRAC = 8;

  localparam logic [FXP_W-1:0] FXP_MAX = 16'h7FFF;
  localparam logic [FXP_W-1:0] FXP_MIN = 16'h8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } fxp_div_state_t;

  // Unsigned magnitude of a two's-complement word; 0x8000 maps to 32768.
  function automatic logic [FXP_W-1:0] fxp_abs(input logic [FXP_W-1:0] v);
    return v[FXP_W-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/fxp_div_step.sv
// One restoring-division iteration: shift the next numerator bit into the
// partial remainder, trial-subtract the divisor, keep the difference when
// it does not go negative.
module fxp_div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             nbit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             qbit
);

  logic [WIDTH:0] shifted;

  // Remainder stays below the divisor, so the shifted value fits WIDTH+1 bits.
  always_comb begin
    shifted = {rem_in, nbit};
    qbit    = (shifted >= {1'b0, divisor});
    rem_out = qbit ? WIDTH'(shifted - {1'b0, divisor}) : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/fxp_div.sv
// Sequential signed Q8.8 divider (restoring, one quotient bit per clock).
// Optional build macro: FXP_DIV_ROUND_EN -- computes one extra quotient bit
// and rounds the magnitude to nearest (ties away from zero) before saturation.
// Without it the quotient truncates toward zero.
module fxp_div
  import fxp_pkg::*;
#(
  parameter int WIDTH = FXP_W,
  parameter int FRAC  = FXP_FRAC
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_valid,
  output logic                    start_ready,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [WIDTH-1:0] quotient,
  output logic                    div_by_zero,
  output logic                    overflow
);

`ifdef FXP_DIV_ROUND_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif
  // Numerator |a| << FRAC, plus one guard bit when rounding.
  localparam int NW   = WIDTH + FRAC + RB;
  localparam int MW   = NW + 1;
  localparam int ITER = NW;
  localparam int CW   = $clog2(ITER + 1);

  fxp_div_state_t state, state_nxt;

  logic             accept;
  logic [NW-1:0]    num_r;
  logic [NW-1:0]    quo_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] dvs_r;
  logic [CW-1:0]    cnt_r;
  logic             sign_r;
  logic             a_neg_r;
  logic             dbz_r;
  logic [WIDTH-1:0] rem_nxt;
  logic             qbit;
  logic [WIDTH:0]   fin;

  function automatic logic [MW-1:0] round_mag(input logic [NW-1:0] q);
`ifdef FXP_DIV_ROUND_EN
    // q carries one extra fractional bit; adding half an LSB rounds ties up.
    return ({1'b0, q} + MW'(1)) >> 1;
`else
    return {1'b0, q};
`endif
  endfunction

  // Returns {overflow, quotient}: clamp the magnitude to the side of the
  // range selected by the sign, otherwise apply the sign.
  function automatic logic [WIDTH:0] saturate(input logic [MW-1:0] mag, input logic neg);
    logic [MW-1:0] limit;
    limit = neg ? MW'(FXP_MIN) : MW'(FXP_MAX);
    if (mag > limit)
      return {1'b1, neg ? WIDTH'(FXP_MIN) : WIDTH'(FXP_MAX)};
    return {1'b0, neg ? (~mag[WIDTH-1:0] + 1'b1) : mag[WIDTH-1:0]};
  endfunction

  fxp_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_r),
    .nbit    (num_r[NW-1]),
    .divisor (dvs_r),
    .rem_out (rem_nxt),
    .qbit    (qbit)
  );

  assign accept = start_valid & start_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: divide-by-zero skips the iterations entirely.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (b == '0) ? DONE : CALC;
      CALC: if (cnt_r == CW'(ITER - 1)) state_nxt = DONE;
      DONE: if (res_valid && res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: operands are only taken while idle.
  always_comb begin
    start_ready = (state == IDLE);
  end

  // Final result selection from the raw quotient magnitude.
  always_comb begin
    if (dbz_r) fin = {1'b0, a_neg_r ? WIDTH'(FXP_MIN) : WIDTH'(FXP_MAX)};
    else       fin = saturate(round_mag(quo_r), sign_r);
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_r       <= '0;
      quo_r       <= '0;
      rem_r       <= '0;
      dvs_r       <= '0;
      cnt_r       <= '0;
      sign_r      <= 1'b0;
      a_neg_r     <= 1'b0;
      dbz_r       <= 1'b0;
      res_valid   <= 1'b0;
      quotient    <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (accept) begin
        sign_r  <= a[WIDTH-1] ^ b[WIDTH-1];
        a_neg_r <= a[WIDTH-1];
        dbz_r   <= (b == '0);
        dvs_r   <= fxp_abs(b);
        num_r   <= {fxp_abs(a), {(FRAC + RB){1'b0}}};
        quo_r   <= '0;
        rem_r   <= '0;
        cnt_r   <= '0;
      end else if (state == CALC) begin
        num_r <= num_r << 1;
        rem_r <= rem_nxt;
        quo_r <= {quo_r[NW-2:0], qbit};
        cnt_r <= cnt_r + 1'b1;
      end

      // First DONE cycle finalizes; outputs then hold until the handshake.
      if (state == DONE && !res_valid) begin
        res_valid   <= 1'b1;
        quotient    <= fin[WIDTH-1:0];
        overflow    <= fin[WIDTH];
        div_by_zero <= dbz_r;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fxp_div.sv
// Scoreboard bench for fxp_div: directed cases and randomized operands
// against an integer-arithmetic reference model.
module tb_fxp_div;

`ifdef FXP_DIV_ROUND_EN
  localparam int          LAT     = 26;
  localparam logic [15:0] Q_2_BY_3 = 16'h00AB;
`else
  localparam int          LAT     = 25;
  localparam logic [15:0] Q_2_BY_3 = 16'h00AA;
`endif

  typedef struct packed {
    logic [15:0] q;
    logic        dbz;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] quotient;
  logic        div_by_zero;
  logic        overflow;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t scb[$];
  exp_t mon_e;

  fxp_div dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a_in),
    .b           (b_in),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .quotient    (quotient),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Reference: real-valued a/b in Q8.8 with integer arithmetic.
  function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv);
    int     sa, sbv, ma, mb;
    longint mag, limit;
    bit     neg;
    exp_t   r;
    sa  = int'($signed(av));
    sbv = int'($signed(bv));
    if (sbv == 0) begin
      r.q   = (sa < 0) ? 16'h8000 : 16'h7FFF;
      r.dbz = 1'b1;
      r.ovf = 1'b0;
      return r;
    end
    ma  = (sa < 0) ? -sa : sa;
    mb  = (sbv < 0) ? -sbv : sbv;
    neg = (sa < 0) != (sbv < 0);
`ifdef FXP_DIV_ROUND_EN
    mag = (longint'(ma) * 512 + longint'(mb)) / (2 * longint'(mb));
`else
    mag = (longint'(ma) * 256) / longint'(mb);
`endif
    limit = neg ? 32768 : 32767;
    r.dbz = 1'b0;
    if (mag > limit) begin
      r.q   = neg ? 16'h8000 : 16'h7FFF;
      r.ovf = 1'b1;
    end else begin
      r.q   = neg ? 16'(-mag) : 16'(mag);
      r.ovf = 1'b0;
    end
    return r;
  endfunction

  // Monitor: compare each result at its handshake against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (scb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_result: got quotient 0x%0h with no divide outstanding", quotient);
      end else begin
        mon_e = scb.pop_front();
        chk("quotient", 32'(quotient), 32'(mon_e.q));
        chk("div_by_zero", 32'(div_by_zero), 32'(mon_e.dbz));
        chk("overflow", 32'(overflow), 32'(mon_e.ovf));
      end
    end
  end

  // One divide: issue, measure latency, optionally stall the result, release.
  task automatic run_div(input logic [15:0] av, input logic [15:0] bv, input exp_t e, input int hold);
    int n;
    int lat;
    lat = (bv == 16'h0000) ? 1 : LAT;
    res_ready = (hold == 0);
    chk("start_ready_idle_before", 32'(start_ready), 32'd1);
    start_valid = 1'b1;
    a_in = av;
    b_in = bv;
    scb.push_back(e);
    @(posedge clk); #1;
    start_valid = 1'b0;
    a_in = 16'($urandom);
    b_in = 16'($urandom);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!res_valid && n < 100);
    chk("latency", 32'(n), 32'(lat));
    for (int i = 0; i < hold; i++) begin
      start_valid = 1'b1;
      a_in = 16'($urandom);
      b_in = 16'($urandom);
      @(posedge clk); #1;
      chk("hold_res_valid", 32'(res_valid), 32'd1);
      chk("hold_start_ready", 32'(start_ready), 32'd0);
      chk("hold_quotient", 32'(quotient), 32'(e.q));
      chk("hold_flags", {30'd0, div_by_zero, overflow}, {30'd0, e.dbz, e.ovf});
    end
    start_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    chk("res_valid_drop", 32'(res_valid), 32'd0);
    chk("start_ready_after", 32'(start_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] ra, rb;
    int          sel;

    #1;
    chk("reset_start_ready", 32'(start_ready), 32'd1);
    chk("reset_res_valid", 32'(res_valid), 32'd0);
    chk("reset_quotient", 32'(quotient), 32'd0);
    chk("reset_flags", {30'd0, div_by_zero, overflow}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_div(16'h0300, 16'h0200, {16'h0180, 1'b0, 1'b0}, 0);
    run_div(16'hFD00, 16'h0200, {16'hFE80, 1'b0, 1'b0}, 0);
    run_div(16'h0200, 16'h0300, {Q_2_BY_3, 1'b0, 1'b0}, 0);
    run_div(16'h7F00, 16'h0080, {16'h7FFF, 1'b0, 1'b1}, 0);
    run_div(16'h8000, 16'h0080, {16'h8000, 1'b0, 1'b1}, 0);
    run_div(16'hFF00, 16'h0000, {16'h8000, 1'b1, 1'b0}, 0);
    run_div(16'h0100, 16'h0000, {16'h7FFF, 1'b1, 1'b0}, 1);
    run_div(16'h0300, 16'h0200, {16'h0180, 1'b0, 1'b0}, 10);
    run_div(16'hFD00, 16'h0200, {16'hFE80, 1'b0, 1'b0}, 0);

    // Abort mid-calculation; the pending result must never appear.
    res_ready = 1'b1;
    start_valid = 1'b1;
    a_in = 16'h1234;
    b_in = 16'h0321;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_res_valid", 32'(res_valid), 32'd0);
    chk("abort_start_ready", 32'(start_ready), 32'd1);
    chk("abort_quotient", 32'(quotient), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("no_stale_result", 32'(res_valid), 32'd0);
    run_div(16'h0600, 16'hFE00, model(16'h0600, 16'hFE00), 0);

    for (int k = 0; k < 30; k++) begin
      sel = $urandom_range(0, 9);
      ra = 16'($urandom);
      rb = 16'($urandom);
      case (sel)
        0: rb = 16'h0000;
        1: rb = 16'h0001;
        2: rb = 16'h8000;
        3: ra = 16'h8000;
        4: ra = 16'h0000;
        5: rb = 16'($urandom_range(1, 255));
        default: ;
      endcase
      run_div(ra, rb, model(ra, rb), $urandom_range(0, 3));
    end

    @(posedge clk); #1;
    chk("scoreboard_drained", 32'(scb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
